// File: rtl/pong_pkg.sv
// Shared definitions for the pong video path.
//   X_MAX_DEF / Y_MAX_DEF : default screen size in pixels
//   COLOUR_W              : width of a pixel colour (1 bit per R/G/B)
//   BLACK..YELLOW         : named colours
//   arb_state_t           : pixel write arbiter states
package pong_pkg;

  localparam int X_MAX_DEF = 160;
  localparam int Y_MAX_DEF = 120;
  localparam int COLOUR_W  = 3;

  // colour bits are {R, G, B}
  localparam logic [COLOUR_W-1:0] BLACK  = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE  = 3'b111;
  localparam logic [COLOUR_W-1:0] RED    = 3'b100;
  localparam logic [COLOUR_W-1:0] GREEN  = 3'b010;
  localparam logic [COLOUR_W-1:0] YELLOW = 3'b110;

  typedef enum logic {
    ARB    = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority search.
//   valid : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot grant to the first valid index at or after ptr (mod N)
//   idx   : binary index of the grant (equals ptr when nothing is valid)
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] idx
);

  logic found;

  always_comb begin
    grant = '0;
    idx   = ptr;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && valid[(int'(ptr) + k) % N]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx = PW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Arbitrates pixel writes from NUM_REQ requesters onto one VGA write port.
// Round-robin between requesters; a requester may lock the port for a run
// of beats (up to LOCK_MAX) by holding req_lock. A frame tick restarts the
// rotation at index 0 at the next arbitration point.
//   clk, rst (async, active low)
//   frame                 : one-cycle frame tick
//   req_valid/req_lock    : per-requester handshake / keep-grant
//   req_x/req_y/req_colour: packed per-requester beat data
//   req_ready             : one-hot grant
//   plot, x, y, colour    : registered write port (latency 1)
//   busy                  : in a locked run
//   clip_count            : saturating off-screen beat counter
// Build option: define PIXEL_ARB_CLIP_EN to drop off-screen beats and count them.
module pixel_write_arbiter
  import pong_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int X_MAX    = X_MAX_DEF,
  parameter int Y_MAX    = Y_MAX_DEF,
  parameter int LOCK_MAX = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_lock,
  input  logic [NUM_REQ*8-1:0]        req_x,
  input  logic [NUM_REQ*8-1:0]        req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0] req_colour,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        plot,
  output logic [7:0]                  x,
  output logic [7:0]                  y,
  output logic [COLOUR_W-1:0]         colour,
  output logic                        busy,
  output logic [7:0]                  clip_count
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [8:0] XM = 9'(X_MAX);
  localparam logic [8:0] YM = 9'(Y_MAX);
`ifdef PIXEL_ARB_CLIP_EN
  localparam bit CLIP_EN = 1'b1;
`else
  localparam bit CLIP_EN = 1'b0;
`endif

  logic [NUM_REQ-1:0][7:0]          xs, ys;
  logic [NUM_REQ-1:0][COLOUR_W-1:0] cs;
  assign xs = req_x;
  assign ys = req_y;
  assign cs = req_colour;

  arb_state_t    state, state_nx;
  logic [PW-1:0] rr_ptr, rr_ptr_nx, lock_owner, lock_owner_nx;
  logic [CW-1:0] lock_cnt, lock_cnt_nx;
  logic          frame_pend, frame_pend_nx;

  logic [NUM_REQ-1:0] pick_grant, grant;
  logic [PW-1:0]      pick_idx, gidx, gidx_inc;
  logic               accept, beat_lock, clip;

  rr_priority_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
    .valid (req_valid),
    .ptr   (rr_ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_comb begin
    grant = '0;
    gidx  = pick_idx;
    if (state == ARB) begin
      grant = pick_grant;
    end else begin
      grant[lock_owner] = 1'b1;
      gidx = lock_owner;
    end
  end

  // rst gates ready so nothing handshakes while reset is held
  assign req_ready = rst ? grant : '0;
  assign accept    = |(req_valid & req_ready);
  assign beat_lock = req_lock[gidx];
  assign gidx_inc  = (int'(gidx) == NUM_REQ - 1) ? '0 : gidx + 1'b1;
  assign clip      = CLIP_EN && (({1'b0, xs[gidx]} >= XM) || ({1'b0, ys[gidx]} >= YM));
  assign busy      = (state == LOCKED);

  always_comb begin
    state_nx      = state;
    rr_ptr_nx     = rr_ptr;
    lock_owner_nx = lock_owner;
    lock_cnt_nx   = lock_cnt;
    frame_pend_nx = frame_pend | frame;
    case (state)
      ARB: begin
        if (accept) begin
          if (beat_lock) begin
            // pointer and any pending frame are held until the run ends
            state_nx      = LOCKED;
            lock_owner_nx = gidx;
            lock_cnt_nx   = CW'(1);
          end else begin
            rr_ptr_nx     = (frame_pend | frame) ? '0 : gidx_inc;
            frame_pend_nx = 1'b0;
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          lock_cnt_nx = lock_cnt + 1'b1;
          if (!beat_lock || (lock_cnt_nx >= CW'(LOCK_MAX))) begin
            state_nx      = ARB;
            rr_ptr_nx     = (frame_pend | frame) ? '0 : gidx_inc;
            frame_pend_nx = 1'b0;
          end
        end
      end
      default: state_nx = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ARB;
      rr_ptr     <= '0;
      lock_owner <= '0;
      lock_cnt   <= '0;
      frame_pend <= 1'b0;
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      colour     <= '0;
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_ptr_nx;
      lock_owner <= lock_owner_nx;
      lock_cnt   <= lock_cnt_nx;
      frame_pend <= frame_pend_nx;
      plot       <= accept & ~clip;
      if (accept && !clip) begin
        x      <= xs[gidx];
        y      <= ys[gidx];
        colour <= cs[gidx];
      end
    end
  end

`ifdef PIXEL_ARB_CLIP_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      clip_count <= '0;
    else if (accept && clip && clip_count != 8'hFF)
      clip_count <= clip_count + 1'b1;
  end
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter (NUM_REQ=4).
module tb_pixel_write_arbiter;
  localparam int N = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic frame = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_lock  = '0;
  logic [N-1:0][7:0] xs, ys;
  logic [N-1:0][2:0] cs;
  logic [N-1:0] req_ready;
  logic plot, busy;
  logic [7:0] x, y, clip_count;
  logic [2:0] colour;

  pixel_write_arbiter #(.NUM_REQ(N)) dut (
    .clk(clk), .rst(rst), .frame(frame),
    .req_valid(req_valid), .req_lock(req_lock),
    .req_x(xs), .req_y(ys), .req_colour(cs),
    .req_ready(req_ready), .plot(plot), .x(x), .y(y), .colour(colour),
    .busy(busy), .clip_count(clip_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [7:0] bx; logic [7:0] by; logic [2:0] bc; } beat_t;
  typedef struct { logic [3:0] v; logic [3:0] l; logic [3:0] er; logic eb; } vec_t;

  beat_t sb[$];
  int n_chk = 0, n_fail = 0, kk = 0;
  bit force_clip = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic set_data();
    for (int i = 0; i < N; i++) begin
      xs[i] = 8'(i * 30 + kk % 25);
      ys[i] = 8'(i * 25 + kk % 20);
      cs[i] = 3'(i + kk);
    end
    if (force_clip) begin
      xs[0] = 8'd160;
      ys[0] = 8'd5;
    end
  endtask

  // One bus cycle: inputs already driven; check ready/busy mid-cycle,
  // queue the expected beat, then check the write port after the edge.
  task automatic cyc(input string nm, input logic [3:0] er, input logic eb);
    beat_t b;
    int g;
    @(negedge clk);
    chk({nm, " ready"}, 32'(req_ready), 32'(er));
    chk({nm, " busy"}, 32'(busy), 32'(eb));
    g = -1;
    for (int i = 0; i < N; i++) if (er[i]) g = i;
    if (g >= 0 && req_valid[g]) begin
      b = '{xs[g], ys[g], cs[g]};
`ifdef PIXEL_ARB_CLIP_EN
      if (!(xs[g] >= 8'd160 || ys[g] >= 8'd120)) sb.push_back(b);
`else
      sb.push_back(b);
`endif
    end
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      b = sb.pop_front();
      chk({nm, " plot"}, 32'(plot), 32'd1);
      chk({nm, " x"}, 32'(x), 32'(b.bx));
      chk({nm, " y"}, 32'(y), 32'(b.by));
      chk({nm, " colour"}, 32'(colour), 32'(b.bc));
    end else begin
      chk({nm, " plot"}, 32'(plot), 32'd0);
    end
    kk++;
    set_data();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    req_valid = '1;
    req_lock = '0;
    frame = 1'b0;
    #1;
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst plot", 32'(plot), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst xyc", {13'd0, x, y, colour}, 32'd0);
    chk("rst clip", 32'(clip_count), 32'd0);
    @(posedge clk);
    #1;
    chk("rst ready held", 32'(req_ready), 32'd0);
    rst = 1'b1;
    req_valid = '0;
    sb.delete();
  endtask

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
    tbl[1]  = '{4'b1111, 4'b0000, 4'b0010, 1'b0};
    tbl[2]  = '{4'b1111, 4'b0000, 4'b0100, 1'b0};
    tbl[3]  = '{4'b1111, 4'b0000, 4'b1000, 1'b0};
    tbl[4]  = '{4'b1111, 4'b0000, 4'b0001, 1'b0};
    tbl[5]  = '{4'b1010, 4'b0000, 4'b0010, 1'b0};
    tbl[6]  = '{4'b1001, 4'b0000, 4'b1000, 1'b0};
    tbl[7]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0};
    tbl[8]  = '{4'b0100, 4'b0000, 4'b0100, 1'b0};
    tbl[9]  = '{4'b0011, 4'b0000, 4'b0001, 1'b0};
    tbl[10] = '{4'b0100, 4'b0100, 4'b0100, 1'b0};
    tbl[11] = '{4'b0001, 4'b0000, 4'b0100, 1'b1};
    tbl[12] = '{4'b0101, 4'b0000, 4'b0100, 1'b1};
    tbl[13] = '{4'b1111, 4'b0000, 4'b1000, 1'b0};

    set_data();
    do_reset();

    // round robin, idle and a short locked run with owner stall
    for (int i = 0; i < 14; i++) begin
      req_valid = tbl[i].v;
      req_lock  = tbl[i].l;
      cyc($sformatf("vec%0d", i), tbl[i].er, tbl[i].eb);
    end

    // 16-beat locked run by req 2, then rotation continues at 3
    do_reset();
    req_valid = 4'b0010; req_lock = 4'b0000;
    cyc("lk16 pre", 4'b0010, 1'b0);
    req_valid = 4'b1111; req_lock = 4'b0100;
    for (int b = 1; b <= 16; b++) begin
      if (b == 16) req_lock = 4'b0000;
      cyc($sformatf("lk16 b%0d", b), 4'b0100, b > 1);
    end
    cyc("lk16 after", 4'b1000, 1'b0);

    // forced release after LOCK_MAX beats
    do_reset();
    req_valid = 4'b0010; req_lock = 4'b0010;
    cyc("lkmax b1", 4'b0010, 1'b0);
    req_valid = 4'b1011;
    for (int b = 2; b <= 255; b++) cyc("lkmax run", 4'b0010, 1'b1);
    cyc("lkmax release", 4'b1000, 1'b0);

    // frame during lock restarts rotation at 0
    do_reset();
    req_valid = 4'b0010; req_lock = 4'b0010;
    cyc("frm b1", 4'b0010, 1'b0);
    req_valid = 4'b1011;
    cyc("frm b2", 4'b0010, 1'b1);
    frame = 1'b1;
    cyc("frm b3", 4'b0010, 1'b1);
    frame = 1'b0;
    cyc("frm b4", 4'b0010, 1'b1);
    req_lock = 4'b0000;
    cyc("frm rel", 4'b0010, 1'b1);
    cyc("frm grant0", 4'b0001, 1'b0);
    // frame in the release cycle
    req_valid = 4'b0010; req_lock = 4'b0010;
    cyc("frmrel b1", 4'b0010, 1'b0);
    req_valid = 4'b1011; req_lock = 4'b0000; frame = 1'b1;
    cyc("frmrel rel", 4'b0010, 1'b1);
    frame = 1'b0;
    cyc("frmrel grant0", 4'b0001, 1'b0);
    // same run without a frame continues past the owner
    req_valid = 4'b0010; req_lock = 4'b0010;
    cyc("nofrm b1", 4'b0010, 1'b0);
    req_valid = 4'b1011; req_lock = 4'b0000;
    cyc("nofrm rel", 4'b0010, 1'b1);
    cyc("nofrm grant3", 4'b1000, 1'b0);

    // off-screen beat
    do_reset();
    force_clip = 1'b1;
    set_data();
    req_valid = 4'b0001; req_lock = 4'b0000;
    cyc("clip b1", 4'b0001, 1'b0);
`ifdef PIXEL_ARB_CLIP_EN
    chk("clip cnt1", 32'(clip_count), 32'd1);
    for (int b = 2; b <= 300; b++) cyc("clip run", 4'b0001, 1'b0);
    chk("clip sat", 32'(clip_count), 32'd255);
`else
    chk("clip cnt0", 32'(clip_count), 32'd0);
`endif
    force_clip = 1'b0;
    set_data();

    // reset in the middle of a locked run
    do_reset();
    req_valid = 4'b0010; req_lock = 4'b0010;
    cyc("mid b1", 4'b0010, 1'b0);
    req_valid = 4'b1111;
    cyc("mid b2", 4'b0010, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid rst plot", 32'(plot), 32'd0);
    chk("mid rst ready", 32'(req_ready), 32'd0);
    chk("mid rst busy", 32'(busy), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b1;
    req_lock = 4'b0000;
    cyc("mid after", 4'b0001, 1'b0);
    cyc("mid next", 4'b0010, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_write_arbiter.md
PIXEL_WRITE_ARBITER -- requirements
Module: pixel_write_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of pixel-write requesters (2..8).
REQ-002 Parameter: X_MAX, 160, screen width in pixels.
REQ-003 Parameter: Y_MAX, 120, screen height in pixels.
REQ-004 Parameter: LOCK_MAX, 255, maximum beats in one locked run before forced release.
REQ-005 clk  input  1  single clock for the block.
REQ-006 rst  input  1  reset, asynchronous and active-low.
REQ-007 frame  input  1  one-cycle frame tick.
REQ-008 req_valid  input  NUM_REQ  per-requester pixel valid.
REQ-009 req_lock  input  NUM_REQ  per-requester "more beats follow, keep grant".
REQ-010 req_x  input  NUM_REQ*8  packed x coordinates, requester i at [8i+7:8i].
REQ-011 req_y  input  NUM_REQ*8  packed y coordinates.
REQ-012 req_colour  input  NUM_REQ*3  packed colours.
REQ-013 req_ready  output  NUM_REQ  one-hot grant; a beat transfers when valid and ready are both high.
REQ-014 plot  output  1  write strobe to the VGA adapter.
REQ-015 x  output  8  write x.
REQ-016 y  output  8  write y.
REQ-017 colour  output  3  write colour.
REQ-018 busy  output  1  high while in LOCKED.
REQ-019 clip_count  output  8  clipped-beat counter.

Function
REQ-020 The FSM SHALL have states ARB and LOCKED.
REQ-021 In ARB, req_ready SHALL be combinational one-hot: the first valid requester at or after rr_ptr, in increasing index order modulo NUM_REQ; all zero if no requester is valid.
REQ-022 In LOCKED, req_ready SHALL be high only for lock_owner, regardless of other valids.
REQ-023 An accepted beat SHALL appear on x/y/colour with plot=1 exactly one cycle later (latency 1); plot=0 in any cycle following a cycle without an accepted beat.
REQ-024 Accepted beat with req_lock=1 in ARB: go to LOCKED, lock_owner=granted index, lock_cnt=1.
REQ-025 In LOCKED, each accepted beat SHALL increment lock_cnt; return to ARB when the accepted beat has req_lock=0 or lock_cnt reaches LOCK_MAX.
REQ-026 On each transition to, or remaining in, ARB after an accepted beat, rr_ptr SHALL become (granted index + 1) mod NUM_REQ; entering LOCKED leaves rr_ptr unchanged until release.
REQ-027 Owner deasserting req_valid in LOCKED SHALL NOT release the lock (stall only).
REQ-028 A frame pulse SHALL set frame_pend; at the next arbitration point in ARB, rr_ptr SHALL be forced to 0 instead of the REQ-026 value, and frame_pend cleared.
REQ-029 frame in the same cycle as a release SHALL be applied at that release (rr_ptr=0).
REQ-030 x/y/colour SHALL hold their last values while plot=0.

Reset
REQ-031 On rst low, asynchronously: state=ARB, rr_ptr=0, lock_owner=0, lock_cnt=0, frame_pend=0, plot=0, x=0, y=0, colour=0, clip_count=0, busy=0; req_ready SHALL be all zero while rst is low.
REQ-032 Reset mid-LOCKED SHALL abandon the run; the first cycle after reset arbitrates from index 0.

Configuration
REQ-033 Macro PIXEL_ARB_CLIP_EN: when defined, accepted beats with x>=X_MAX or y>=Y_MAX SHALL still be acknowledged but produce plot=0, and clip_count SHALL increment, saturating at 255.
REQ-034 Without PIXEL_ARB_CLIP_EN, all accepted beats SHALL be plotted unmodified and clip_count SHALL be constant 0.

Structure
REQ-035 Shared package pong_pkg SHALL hold X_MAX/Y_MAX defaults, COLOUR_W=3, colour constants (BLACK, WHITE, RED, GREEN, YELLOW) and the arbiter state enum.
REQ-036 The rotating priority search SHALL be a sub-module rr_priority_pick (inputs valid vector, pointer; output one-hot grant and index).

Verification
REQ-037 Reqs 0..3 all valid, no lock, from reset -> grants 0,1,2,3,0 on consecutive cycles; plot pulses one cycle after each.
REQ-038 Req 2 sends 16 beats with lock=1 on first 15, reqs 0/1 valid throughout -> only req 2 ready for 16 beats, busy high, then grant goes to req 3 index order (rr_ptr=3).
REQ-039 Req 1 holds lock=1 for 300 beats -> forced release after beat 255, next grant to another valid requester.
REQ-040 frame pulse during a locked run of req 1 with reqs 0 and 3 valid -> after release, req 0 granted.
REQ-041 With PIXEL_ARB_CLIP_EN, beat x=160,y=5 -> acknowledged, plot stays 0, clip_count 0->1; 300 such beats -> clip_count 255.
REQ-042 rst low mid-lock with plot=1 -> plot, req_ready, busy drop immediately; after release, req 0 granted first.
